// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Input conditioning for a single-bit asynchronous level input such as a
// push-button or switch. The raw input is brought into the clk domain through
// a two-flop synchroniser. Contact bounce is then filtered by requiring
// STABLE_CYCLES consecutive synchronised samples that disagree with the
// current output before the output is allowed to change. The result is a
// clean registered level plus single-cycle rise/fall strobes.
//
// Parameters:
//   STABLE_CYCLES  consecutive disagreeing samples needed to change btn_out
//                  (legal range 1 .. 2**CNT_WIDTH)
//   CNT_WIDTH      width of the debounce counter
//
// Ports:
//   clk         sole clock, all state updates on its rising edge
//   rst         synchronous, active-high reset
//   btn_in      raw asynchronous input, may bounce
//   btn_out     debounced level (registered)
//   rise_pulse  one-cycle strobe coinciding with btn_out first reading 1
//   fall_pulse  one-cycle strobe coinciding with btn_out first reading 0
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   // The counter reaches this value on the last disagreeing sample still
   // needed; the next disagreeing sample commits the new level.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

   // LOW_* states hold btn_out = 0, HIGH_* states hold btn_out = 1. The
   // *_TO_* states mean a change is being qualified.
   typedef enum logic [1:0] {
      LOW_STABLE,
      LOW_TO_HIGH,
      HIGH_STABLE,
      HIGH_TO_LOW
   } state_t;

   state_t               state;
   logic                 s1;
   logic                 s2;
   logic [CNT_WIDTH-1:0] cnt;

   // NOTE: every register here is written with <= so that all flops sample
   // the values from before the edge; with = the synchroniser would collapse
   // into a single flop and s2 would see btn_in one cycle early.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         cnt        <= '0;
         state      <= LOW_STABLE;
         btn_out    <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;

         // Strobes default low so each one lasts exactly one cycle.
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;

         case (state)
            LOW_STABLE, LOW_TO_HIGH: begin
               if (!s2) begin
                  // Agreement with the output: any partial count is a bounce.
                  cnt   <= '0;
                  state <= LOW_STABLE;
               end else if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  state      <= HIGH_STABLE;
                  btn_out    <= 1'b1;
                  rise_pulse <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
                  state <= LOW_TO_HIGH;
               end
            end

            default: begin  // HIGH_STABLE, HIGH_TO_LOW
               if (s2) begin
                  cnt   <= '0;
                  state <= HIGH_STABLE;
               end else if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  state      <= LOW_STABLE;
                  btn_out    <= 1'b0;
                  fall_pulse <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
                  state <= HIGH_TO_LOW;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Directed stimulus for btn_debounce with STABLE_CYCLES = 4. Edges are
// numbered from 1; every input value is recorded against the edge that
// samples it. A window-based model derives the expected outputs from the
// recorded inputs: the level flips at edge k when the last STABLE_CYCLES
// filter samples (edges k-S+1..k, all after the last reset edge) disagree
// with the current level. The filter sample at edge k is btn_in from edge
// k-2, or 0 if either of the two edges in between was a reset edge.
// Every cycle the DUT is compared with that model, and at the end a set of
// hand-computed literals pins both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

   localparam int S  = 4;
   localparam int NE = 1200;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic btn_in = 1'b1;
   logic btn_out;
   logic rise_pulse;
   logic fall_pulse;

   always #5 clk = ~clk;

   btn_debounce #(
      .STABLE_CYCLES(S),
      .CNT_WIDTH    (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in),
      .btn_out   (btn_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Inputs as sampled at each edge.
   bit in_at  [NE];
   bit rst_at [NE];
   // Model expectations and DUT observations after each edge.
   bit          exp_out  [NE];
   logic        obs_out  [NE];
   logic        obs_rise [NE];
   logic        obs_fall [NE];
   logic [15:0] obs_cnt  [NE];

   int d_edge = 1;   // edge that the current drive values apply to

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Hold btn_in = b, rst = r for the next n edges.
   task automatic seg(input bit b, input bit r, input int n);
      repeat (n) begin
         @(negedge clk);
         btn_in = b;
         rst    = r;
         d_edge++;
         in_at[d_edge]  = b;
         rst_at[d_edge] = r;
      end
   endtask

   // Value the debounce filter sees at edge k.
   function automatic bit filt(input int k);
      if (k < 3) return 1'b0;
      if (rst_at[k-1] || rst_at[k-2]) return 1'b0;
      return in_at[k-2];
   endfunction

   // Per-cycle model and compare.
   initial begin
      int k        = 0;
      int last_rst = 0;
      bit m_out    = 1'b0;
      bit m_rise   = 1'b0;
      bit m_fall   = 1'b0;
      bit flip;
      forever begin
         @(negedge clk);
         k++;
         if (rst_at[k]) begin
            m_out    = 1'b0;
            m_rise   = 1'b0;
            m_fall   = 1'b0;
            last_rst = k;
         end else begin
            flip = (k - last_rst >= S);
            for (int j = k - S + 1; j <= k; j++)
               if (j > last_rst && filt(j) == m_out) flip = 1'b0;
            m_rise = flip && !m_out;
            m_fall = flip && m_out;
            if (flip) m_out = !m_out;
         end
         exp_out[k]  = m_out;
         obs_out[k]  = btn_out;
         obs_rise[k] = rise_pulse;
         obs_fall[k] = fall_pulse;
         obs_cnt[k]  = dut.cnt;
         check($sformatf("e%0d_btn_out", k), btn_out, m_out);
         check($sformatf("e%0d_rise", k), rise_pulse, m_rise);
         check($sformatf("e%0d_fall", k), fall_pulse, m_fall);
      end
   end

   // Number of edges in lo..hi where the selected observation is 1
   // (sel 0: btn_out, 1: rise_pulse, 2: fall_pulse, 3: cnt nonzero).
   function automatic int count_set(input int sel, input int lo, input int hi);
      int n = 0;
      for (int e = lo; e <= hi; e++) begin
         case (sel)
            0:       n += (obs_out[e]  === 1'b1) ? 1 : 0;
            1:       n += (obs_rise[e] === 1'b1) ? 1 : 0;
            2:       n += (obs_fall[e] === 1'b1) ? 1 : 0;
            default: n += (obs_cnt[e]  !== 16'd0) ? 1 : 0;
         endcase
      end
      return n;
   endfunction

   initial begin
      // Edge 1 uses the values applied at time 0.
      in_at[1]  = 1'b1;
      rst_at[1] = 1'b1;

      seg(1, 1, 2);     // e2-3    reset held with btn_in high
      seg(1, 0, 17);    // e4-20   fresh press after reset
      seg(0, 0, 10);    // e21-30  release
      seg(1, 0, 9);     // e31-39  clean press
      seg(0, 0, 11);    // e40-50  clean release
      seg(1, 0, 3);     // e51-53  bounce: 3 high
      seg(0, 0, 2);     // e54-55           2 low
      seg(1, 0, 3);     // e56-58           3 high
      seg(0, 0, 12);    // e59-70  low held
      seg(1, 0, 4);     // e71-74  4-cycle excursion
      seg(0, 0, 16);    // e75-90
      seg(1, 0, 3);     // e91-93  press
      seg(1, 1, 1);     // e94     reset mid-count
      seg(1, 0, 1000);  // e95-1094 long hold
      seg(0, 0, 10);    // e1095-1104 release
      repeat (3) @(negedge clk);

      // Reset with btn_in high.
      for (int e = 1; e <= 3; e++)
         check($sformatf("t1_rst_outputs_e%0d", e),
               {obs_out[e], obs_rise[e], obs_fall[e]}, 0);
      check("t1_out_e8",    obs_out[8],  0);
      check("t1_out_e9",    obs_out[9],  1);
      check("t1_rise_e9",   obs_rise[9], 1);
      check("t1_rise_cnt",  count_set(1, 4, 20), 1);
      check("t1_fall_e26",  obs_fall[26], 1);
      check("t1_out_e26",   obs_out[26],  0);

      // Clean press.
      check("t2_out_e35",   obs_out[35],  0);
      check("t2_out_e36",   obs_out[36],  1);
      check("t2_rise_e36",  obs_rise[36], 1);
      check("t2_rise_cnt",  count_set(1, 31, 39), 1);
      check("t2_fall_cnt",  count_set(2, 31, 39), 0);

      // Clean release.
      check("t4_out_e44",   obs_out[44],  1);
      check("t4_out_e45",   obs_out[45],  0);
      check("t4_fall_e45",  obs_fall[45], 1);
      check("t4_fall_cnt",  count_set(2, 40, 50), 1);

      // Bounce rejection, then a 4-cycle excursion that is accepted.
      check("t3_out_high",  count_set(0, 51, 70), 0);
      check("t3_pulses",    count_set(1, 51, 70) + count_set(2, 51, 70), 0);
      check("t3_out_e75",   obs_out[75],  0);
      check("t3_out_e76",   obs_out[76],  1);
      check("t3_rise_e76",  obs_rise[76], 1);
      check("t3_out_e79",   obs_out[79],  1);
      check("t3_out_e80",   obs_out[80],  0);
      check("t3_fall_e80",  obs_fall[80], 1);

      // Reset mid-count.
      check("t5_pulses",    count_set(1, 91, 94) + count_set(2, 91, 94), 0);
      check("t5_out_e99",   obs_out[99],   0);
      check("t5_out_e100",  obs_out[100],  1);
      check("t5_rise_e100", obs_rise[100], 1);

      // Long hold.
      check("t6_rise_cnt",  count_set(1, 95, 1094), 1);
      check("t6_out_const", count_set(0, 100, 1094), 995);
      check("t6_cnt_zero",  count_set(3, 100, 1094), 0);
      check("t6_out_e1100", obs_out[1100], 0);

      // Pin the model itself.
      check("model_e9",    exp_out[9],    1);
      check("model_e36",   exp_out[36],   1);
      check("model_e45",   exp_out[45],   0);
      check("model_e62",   exp_out[62],   0);
      check("model_e76",   exp_out[76],   1);
      check("model_e99",   exp_out[99],   0);
      check("model_e100",  exp_out[100],  1);
      check("model_e1100", exp_out[1100], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
